exc_ctrl: RTL
=============

Name: exc_ctrl

Overview:
- Exception/return sequencer between the write-back stage and CP0 (STATUS.EXL, CAUSE.ExcCode, EPC) and fetch.
- Prioritises per-instruction exception flags at commit and generates CP0 write strobes.
- Holds the pipeline cancel for a programmable number of cycles, then presents the redirect PC to fetch with a valid/ack handshake.
- Handles ERET through the same sequence, redirecting to EPC.

Parameters:
- FLUSH_CYCLES, 2, cycles cancel is held after an event (legal range 1..15).
- EXC_ENTRY, 32'hBFC00380, exception vector.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous reset, active-low
- wb_valid  in  1  WB holds a valid instruction this cycle
- wb_pc  in  32  PC of WB instruction
- fetch_error, inst_reserved, syscall, brk, overflow, raddr_error, waddr_error  in  1 each  exception flags of WB instruction
- eret  in  1  WB instruction is ERET
- epc_rdata  in  32  current CP0 EPC
- redirect_ack  in  1  fetch accepted redirect
- commit_kill  out  1  suppress RF/HI/LO/CP0-mtc0 writes of WB instruction (combinational)
- cause_wen  out  1  CAUSE.ExcCode write strobe
- cause_code  out  5  ExcCode value
- epc_wen  out  1  EPC write strobe
- epc_wdata  out  32  EPC write value
- exl_set  out  1  set STATUS.EXL
- exl_clr  out  1  clear STATUS.EXL
- cancel  out  1  flush all younger stages (registered)
- wb_stall  out  1  block WB from accepting new instructions
- exc_bus  out  33  {redirect valid, redirect PC}

Behaviour:
- Reset (resetn=0 at posedge): state IDLE; counter 0; target_r 0. All outputs 0 while in reset and in IDLE without an event.
- States:
  - IDLE: wb_stall=0, cancel=0, exc_bus[32]=0.
  - FLUSH: cancel=1, wb_stall=1.
  - REDIRECT: exc_bus={1,target_r}, wb_stall=1, cancel=0.
- Event in cycle T: IDLE & wb_valid & (any flag | eret).
- Exception priority, highest first (ExcCode): fetch_error 4, inst_reserved 0xA, syscall 8, brk 9, overflow 0xC, raddr_error 4, waddr_error 5.
- Exception event in cycle T, all combinational:
  - cause_wen=1, cause_code per priority.
  - epc_wen=1, epc_wdata=wb_pc.
  - exl_set=1, commit_kill=1.
  - target_r<=EXC_ENTRY.
- ERET with no exception flag in cycle T:
  - exl_clr=1, commit_kill=0.
  - No cause_wen/epc_wen.
  - target_r<=epc_rdata sampled at T.
- ERET together with any exception flag: the exception wins and ERET is ignored.
- Sequencing and latency:
  - Cycle T+1: state FLUSH, counter loaded 1.
  - cancel is high for exactly FLUSH_CYCLES cycles, T+1..T+FLUSH_CYCLES.
  - When counter==FLUSH_CYCLES, go to REDIRECT.
  - REDIRECT holds exc_bus valid until redirect_ack=1, then returns to IDLE next cycle.
  - Ack in the first REDIRECT cycle gives exactly one valid cycle.
- Flags/eret arriving while state!=IDLE are ignored, and no strobes fire.
- wb_valid=0 with flags set: no event.
- redirect_ack outside REDIRECT is ignored.
- Counter width 4 bits. It saturates at FLUSH_CYCLES and never wraps.
- Reset asserted mid-FLUSH/REDIRECT: IDLE next cycle, cancel and exc_bus drop immediately after that edge, and the pending redirect is discarded.
- Strobes are single-cycle, in cycle T only.

Optional Feature:
- Macro EXC_CTRL_INT_EN.
- When defined, adds inputs int_pending (1), status_ie (1) and status_exl (1).
- Interrupt condition: int_pending & status_ie & ~status_exl & wb_valid in IDLE.
  - The interrupt outranks every exception flag and ERET.
  - cause_code=0, epc_wdata=wb_pc, commit_kill=1, exl_set=1, target EXC_ENTRY.
  - Sequence identical to an exception.
- When not defined, the ports are absent and interrupts are never taken.

Decomposition:
- Package exc_pkg holds:
  - EXCCODE_INT/ADEL/ADES/SYS/BP/RI/OV localparams.
  - State encoding IDLE/FLUSH/REDIRECT (2-bit).
  - Default EXC_ENTRY.
- One natural sub-module, exc_prio_enc: combinational priority encoder from flag vector to {any_exc, cause_code}.

Test Plan:
- syscall at wb_pc=0x1000, FLUSH_CYCLES=2, ack on first REDIRECT cycle → T: cause_code=8, epc_wdata=0x1000, exl_set, commit_kill; cancel T+1..T+2; exc_bus=0x1_BFC00380 at T+3 only; IDLE at T+4.
- inst_reserved+overflow+waddr_error together at 0x2000 → cause_code=0xA, single cause_wen/epc_wen pulse.
- eret with epc_rdata=0x1004, ack delayed 3 cycles → exl_clr, no epc_wen/cause_wen; exc_bus=0x1_00001004 held 4 cycles; wb_stall high throughout.
- brk while in FLUSH of a prior syscall → no strobes; only one redirect produced.
- resetn=0 during REDIRECT → next cycle all outputs 0, state IDLE; a later overflow event then sequences normally (cause 0xC).
- EXC_CTRL_INT_EN defined, int_pending=1, status_ie=1, status_exl=0, syscall at 0x3000 → cause_code=0, epc_wdata=0x3000; repeat with status_exl=1 → cause_code=8.

Source files
------------

// File: rtl/exc_ctrl_pkg.sv
// Shared exception-sequencer definitions: ExcCode values, FSM states, flag layout.
package exc_pkg;

  localparam logic [4:0] EXCCODE_INT  = 5'h00;
  localparam logic [4:0] EXCCODE_ADEL = 5'h04;
  localparam logic [4:0] EXCCODE_ADES = 5'h05;
  localparam logic [4:0] EXCCODE_SYS  = 5'h08;
  localparam logic [4:0] EXCCODE_BP   = 5'h09;
  localparam logic [4:0] EXCCODE_RI   = 5'h0A;
  localparam logic [4:0] EXCCODE_OV   = 5'h0C;

  localparam logic [31:0] EXC_ENTRY_DEFAULT = 32'hBFC00380;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } exc_state_e;

  // Field order is highest priority first.
  typedef struct packed {
    logic fetch_error;
    logic inst_reserved;
    logic syscall;
    logic brk;
    logic overflow;
    logic raddr_error;
    logic waddr_error;
  } exc_flags_t;

endpackage

// File: rtl/exc_ctrl_if.sv
// Redirect handshake between the exception sequencer (master) and fetch (slave).
interface exc_ctrl_if;
  logic [32:0] exc_bus;
  logic        redirect_ack;

  modport master (output exc_bus, input redirect_ack);
  modport slave  (input exc_bus, output redirect_ack);
endinterface

// File: rtl/exc_ctrl_prio_enc.sv
// Fixed-priority encoder from WB exception flags to {any_exc, ExcCode}.
module exc_prio_enc
  import exc_pkg::*;
(
  input  exc_flags_t  flags,
  output logic        any_exc,
  output logic [4:0]  cause_code
);

  always_comb begin
    any_exc    = 1'b1;
    cause_code = '0;
    if      (flags.fetch_error)   cause_code = EXCCODE_ADEL;
    else if (flags.inst_reserved) cause_code = EXCCODE_RI;
    else if (flags.syscall)       cause_code = EXCCODE_SYS;
    else if (flags.brk)           cause_code = EXCCODE_BP;
    else if (flags.overflow)      cause_code = EXCCODE_OV;
    else if (flags.raddr_error)   cause_code = EXCCODE_ADEL;
    else if (flags.waddr_error)   cause_code = EXCCODE_ADES;
    else                          any_exc    = 1'b0;
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/ERET sequencer: commit-time CP0 strobes, timed cancel, redirect handshake.
// Optional interrupt entry enabled by defining EXC_CTRL_INT_EN.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_ENTRY    = EXC_ENTRY_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        fetch_error,
  input  logic        inst_reserved,
  input  logic        syscall,
  input  logic        brk,
  input  logic        overflow,
  input  logic        raddr_error,
  input  logic        waddr_error,
  input  logic        eret,
  input  logic [31:0] epc_rdata,
`ifdef EXC_CTRL_INT_EN
  input  logic        int_pending,
  input  logic        status_ie,
  input  logic        status_exl,
`endif
  exc_ctrl_if.master  redir,
  output logic        commit_kill,
  output logic        cause_wen,
  output logic [4:0]  cause_code,
  output logic        epc_wen,
  output logic [31:0] epc_wdata,
  output logic        exl_set,
  output logic        exl_clr,
  output logic        cancel,
  output logic        wb_stall
);

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES);

  exc_state_e  state;
  logic [3:0]  counter;
  logic [31:0] target_r;
  logic        redir_valid;

  exc_flags_t  flags;
  logic        any_exc;
  logic [4:0]  prio_code;
  logic        int_req;
  logic        slot;
  logic        exc_ev;
  logic        eret_ev;

  assign flags = {fetch_error, inst_reserved, syscall, brk,
                  overflow, raddr_error, waddr_error};

  exc_prio_enc u_prio (
    .flags      (flags),
    .any_exc    (any_exc),
    .cause_code (prio_code)
  );

`ifdef EXC_CTRL_INT_EN
  assign int_req = int_pending & status_ie & ~status_exl;
`else
  assign int_req = 1'b0;
`endif

  // Strobes are gated by resetn so nothing fires while reset is held.
  assign slot    = resetn & (state == IDLE) & wb_valid;
  assign exc_ev  = slot & (int_req | any_exc);
  assign eret_ev = slot & eret & ~int_req & ~any_exc;

  always_comb begin
    cause_wen   = 1'b0;
    cause_code  = '0;
    epc_wen     = 1'b0;
    epc_wdata   = '0;
    exl_set     = 1'b0;
    exl_clr     = 1'b0;
    commit_kill = 1'b0;
    if (exc_ev) begin
      cause_wen   = 1'b1;
      cause_code  = int_req ? EXCCODE_INT : prio_code;
      epc_wen     = 1'b1;
      epc_wdata   = wb_pc;
      exl_set     = 1'b1;
      commit_kill = 1'b1;
    end
    if (eret_ev) exl_clr = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      counter     <= '0;
      target_r    <= '0;
      cancel      <= 1'b0;
      wb_stall    <= 1'b0;
      redir_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (exc_ev || eret_ev) begin
          state    <= FLUSH;
          counter  <= 4'd1;
          cancel   <= 1'b1;
          wb_stall <= 1'b1;
          target_r <= exc_ev ? EXC_ENTRY : epc_rdata;
        end
        FLUSH: begin
          // Counter stops at FLUSH_CYCLES; the compare doubles as saturation.
          if (counter == FLUSH_LAST) begin
            state       <= REDIRECT;
            cancel      <= 1'b0;
            redir_valid <= 1'b1;
          end else begin
            counter <= counter + 4'd1;
          end
        end
        REDIRECT: if (redir.redirect_ack) begin
          state       <= IDLE;
          counter     <= '0;
          redir_valid <= 1'b0;
          wb_stall    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign redir.exc_bus = redir_valid ? {1'b1, target_r} : '0;

endmodule
